// File: rtl/event_capture_pkg.sv
// Shared types and constants for the event capture stage: edge-mode encoding,
// the minimum synchronizer depth and the per-bit edge detector.
package event_capture_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    localparam int MIN_SYNC_STAGES = 2;

    function automatic logic detect_edge(
        input edge_mode_e mode,
        input logic       sync_bit,
        input logic       hist_bit
    );
        logic result;
        case (mode)
            EDGE_RISE: result = sync_bit & ~hist_bit;
            EDGE_FALL: result = ~sync_bit & hist_bit;
            EDGE_BOTH: result = sync_bit ^ hist_bit;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/event_capture_n_sync_chain.sv
// Single-bit multi-flop synchronizer; every stage resets asynchronously to 0.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/event_capture_n.sv
// Per-bit asynchronous event capture: synchronize, detect edges, latch sticky pending bits.
// Optional overflow output enabled by macro EVENT_CAPTURE_OVERFLOW_EN.
module event_capture_n
    import event_capture_pkg::*;
#(
    parameter int NUM_INPUTS  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] async_in,
    input  logic [NUM_INPUTS-1:0] mask,
    input  logic                  clr_valid,
    input  logic [NUM_INPUTS-1:0] clr_mask,
    output logic [NUM_INPUTS-1:0] pending,
    output logic [NUM_INPUTS-1:0] event_pulse,
    output logic                  armed
`ifdef EVENT_CAPTURE_OVERFLOW_EN
    ,
    output logic [NUM_INPUTS-1:0] overflow
`endif
);

    localparam edge_mode_e MODE  = edge_mode_e'(EDGE_MODE[1:0]);
    localparam int         CNT_W = $clog2(SYNC_STAGES + 2);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
        $error("event_capture_n: SYNC_STAGES must be at least 2");
    end
    if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
        $error("event_capture_n: EDGE_MODE must be 0, 1 or 2");
    end

    logic [NUM_INPUTS-1:0] sync_s;
    logic [NUM_INPUTS-1:0] edge_s;
    logic [NUM_INPUTS-1:0] hist_q;
    logic [NUM_INPUTS-1:0] qual_s;
    logic [NUM_INPUTS-1:0] clr_s;
    logic [NUM_INPUTS-1:0] pending_q,  pending_d;
    logic [NUM_INPUTS-1:0] pulse_q;
    logic [CNT_W-1:0]      arm_cnt_q;
    logic                  armed_q;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_bit
        sync_chain #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk(clk),
            .rst(rst),
            .d  (async_in[gi]),
            .q  (sync_s[gi])
        );
        assign edge_s[gi] = detect_edge(MODE, sync_s[gi], hist_q[gi]);
    end

    // A new edge always wins over a same-cycle clear so no event is dropped.
    always_comb begin
        qual_s    = {NUM_INPUTS{armed_q}} & edge_s & mask;
        clr_s     = {NUM_INPUTS{clr_valid}} & clr_mask;
        pending_d = qual_s | (pending_q & ~clr_s);
    end

    // Arming waits long enough that levels present during reset have fully
    // propagated into the history register before edges are honoured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else if (!armed_q) begin
            arm_cnt_q <= arm_cnt_q + CNT_W'(1);
            if (arm_cnt_q == CNT_W'(SYNC_STAGES)) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q    <= '0;
            pending_q <= '0;
            pulse_q   <= '0;
        end else begin
            hist_q    <= sync_s;
            pending_q <= pending_d;
            pulse_q   <= qual_s;
        end
    end

    assign pending     = pending_q;
    assign event_pulse = pulse_q;
    assign armed       = armed_q;

`ifdef EVENT_CAPTURE_OVERFLOW_EN
    logic [NUM_INPUTS-1:0] overflow_q, overflow_d;

    always_comb begin
        overflow_d = (qual_s & pending_q & ~clr_s) | (overflow_q & ~clr_s);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    // Without overflow tracking, repeated events merge silently into pending.
`endif

endmodule

// File: tb/tb_event_capture_n.sv
// Bench for event_capture_n: a rising-edge instance and a both-edge instance
// checked every cycle against a delayed-sample model plus directed literals.
module tb_event_capture_n;

    localparam int N = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] async_v [2];
    logic [N-1:0] mask;
    logic         clr_valid;
    logic [N-1:0] clr_mask;
    logic [N-1:0] pend_o  [2];
    logic [N-1:0] pulse_o [2];
    logic         armed_o [2];
    logic [N-1:0] ovf_o   [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    event_capture_n #(.NUM_INPUTS(N), .SYNC_STAGES(S), .EDGE_MODE(0)) u_rise (
        .clk(clk), .rst(rst), .async_in(async_v[0]), .mask(mask),
        .clr_valid(clr_valid), .clr_mask(clr_mask),
        .pending(pend_o[0]), .event_pulse(pulse_o[0]), .armed(armed_o[0])
`ifdef EVENT_CAPTURE_OVERFLOW_EN
        , .overflow(ovf_o[0])
`endif
    );

    event_capture_n #(.NUM_INPUTS(N), .SYNC_STAGES(S), .EDGE_MODE(2)) u_both (
        .clk(clk), .rst(rst), .async_in(async_v[1]), .mask(mask),
        .clr_valid(clr_valid), .clr_mask(clr_mask),
        .pending(pend_o[1]), .event_pulse(pulse_o[1]), .armed(armed_o[1])
`ifdef EVENT_CAPTURE_OVERFLOW_EN
        , .overflow(ovf_o[1])
`endif
    );

    // Model: the event seen at edge n is an edge between the input sampled at
    // edges n-S-1 and n-S, honoured once S+1 edges have passed since reset.
    logic [N-1:0] samp    [2][0:S];
    int           seen    [2];
    logic [N-1:0] e_pend  [2];
    logic [N-1:0] e_pulse [2];
    logic [N-1:0] e_ovf   [2];
    logic         e_armed [2];

    function automatic logic [N-1:0] model_qual(int m);
        logic [N-1:0] cur;
        logic [N-1:0] prev;
        logic [N-1:0] ed;
        cur  = samp[m][S-1];
        prev = samp[m][S];
        if (m == 0) ed = cur & ~prev;
        else        ed = cur ^ prev;
        if (seen[m] >= S + 1) return ed & mask;
        return '0;
    endfunction

    function automatic logic [N-1:0] model_clr();
        return clr_valid ? clr_mask : '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int j = 0; j <= S; j++) samp[m][j] <= '0;
                seen[m]    <= 0;
                e_pend[m]  <= '0;
                e_pulse[m] <= '0;
                e_ovf[m]   <= '0;
                e_armed[m] <= 1'b0;
            end else begin
                e_pulse[m] <= model_qual(m);
                e_pend[m]  <= model_qual(m) | (e_pend[m] & ~model_clr());
                e_ovf[m]   <= (model_qual(m) & e_pend[m] & ~model_clr())
                              | (e_ovf[m] & ~model_clr());
                e_armed[m] <= (seen[m] + 1 >= S + 1);
                seen[m]    <= (seen[m] < 1000) ? seen[m] + 1 : seen[m];
                samp[m][0] <= async_v[m];
                for (int j = 1; j <= S; j++) samp[m][j] <= samp[m][j-1];
            end
        end
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int m = 0; m < 2; m++) begin
                check($sformatf("pending[%0d]", m), pend_o[m], e_pend[m]);
                check($sformatf("event_pulse[%0d]", m), pulse_o[m], e_pulse[m]);
                check($sformatf("armed[%0d]", m), {7'd0, armed_o[m]}, {7'd0, e_armed[m]});
`ifdef EVENT_CAPTURE_OVERFLOW_EN
                check($sformatf("overflow[%0d]", m), ovf_o[m], e_ovf[m]);
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        async_v[0] = 8'hFF;
        async_v[1] = 8'h00;
        mask       = 8'hFF;
        clr_valid  = 1'b0;
        clr_mask   = 8'h00;
        #1 rst = 1'b1;
        tick(3);
        check("reset pending", pend_o[0], 8'h00);
        check("reset armed", {7'd0, armed_o[0]}, 8'h00);
        rst = 1'b0;

        // 1: levels present at reset never produce events; armed after 3 edges
        tick(2);
        check("t1 armed before 3 edges", {7'd0, armed_o[0]}, 8'h00);
        tick(1);
        check("t1 armed after 3 edges", {7'd0, armed_o[0]}, 8'h01);
        tick(17);
        check("t1 pending", pend_o[0], 8'h00);

        // 2: single rising edge on bit 3
        async_v[0] = 8'hF7;
        tick(5);
        async_v[0] = 8'hFF;
        tick(2);
        check("t2 pending early", pend_o[0], 8'h00);
        tick(1);
        check("t2 pending", pend_o[0], 8'h08);
        check("t2 pulse", pulse_o[0], 8'h08);
        check("t2 model pending", e_pend[0], 8'h08);
        tick(1);
        check("t2 pulse one cycle", pulse_o[0], 8'h00);

        // 3: clear, then clear colliding with a new edge
        clr_valid = 1'b1;
        clr_mask  = 8'h08;
        tick(1);
        clr_valid = 1'b0;
        check("t3 cleared", pend_o[0], 8'h00);
        async_v[0] = 8'hF7;
        tick(4);
        async_v[0] = 8'hFF;
        tick(2);
        clr_valid = 1'b1;
        tick(1);
        clr_valid = 1'b0;
        check("t3 set wins", pend_o[0], 8'h08);
        check("t3 set wins pulse", pulse_o[0], 8'h08);
        clr_valid = 1'b1;
        tick(1);
        clr_valid = 1'b0;
        clr_mask  = 8'hFF;
        check("t3 ignored clr_mask", pend_o[0], 8'h00);
        tick(2);

        // 4: mask F0, simultaneous edges on bits 0 and 7
        mask       = 8'hF0;
        async_v[0] = 8'h7E;
        tick(4);
        async_v[0] = 8'hFF;
        tick(3);
        check("t4 pending", pend_o[0], 8'h80);
        check("t4 pulse", pulse_o[0], 8'h80);
        mask = 8'h00;
        tick(3);
        check("t4 mask change keeps pending", pend_o[0], 8'h80);

        // 5: both-edge instance, rise then fall on bit 1
        mask       = 8'hFF;
        async_v[1] = 8'h02;
        tick(3);
        check("t5 first pulse", pulse_o[1], 8'h02);
        tick(1);
        check("t5 pulse gap", pulse_o[1], 8'h00);
        tick(1);
        async_v[1] = 8'h00;
        tick(3);
        check("t5 second pulse", pulse_o[1], 8'h02);
        check("t5 pending", pend_o[1], 8'h02);
        check("t5 model pending", e_pend[1], 8'h02);
`ifdef EVENT_CAPTURE_OVERFLOW_EN
        check("t5 overflow", ovf_o[1], 8'h02);
`endif
        tick(1);
        check("t5 pulse ends", pulse_o[1], 8'h00);

        // 6: pending A5, then asynchronous reset mid-cycle
        clr_valid = 1'b1;
        clr_mask  = 8'hFF;
        tick(1);
        clr_valid  = 1'b0;
        async_v[0] = 8'h00;
        tick(4);
        async_v[0] = 8'hA5;
        tick(3);
        check("t6 pending A5", pend_o[0], 8'hA5);
        #2 rst = 1'b1;
        #1;
        check("t6 async reset pending", pend_o[0], 8'h00);
        check("t6 async reset pulse", pulse_o[0], 8'h00);
        check("t6 async reset armed", {7'd0, armed_o[0]}, 8'h00);
        check("t6 async reset pending b", pend_o[1], 8'h00);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("t6 rearm before 3 edges", {7'd0, armed_o[0]}, 8'h00);
        tick(1);
        check("t6 rearm after 3 edges", {7'd0, armed_o[0]}, 8'h01);
        tick(10);
        check("t6 no spurious after rearm", pend_o[0], 8'h00);
        async_v[0] = 8'h00;
        tick(4);
        async_v[0] = 8'h01;
        tick(3);
        check("t6 capture after rearm", pend_o[0], 8'h01);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
